// File: rtl/aux_spike_queue.sv
// Time-gated FWFT FIFO of {BT, NID} spike events; the head is released only once Current_BT reaches its BT.
// Optional drop status (Overflow, DropCount) is built when AUXQ_DROP_STATUS_EN is defined.
module aux_spike_queue #(
    parameter int BT_WIDTH     = 36,
    parameter int NEURON_WIDTH = 11,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    EnqueueIn,
    input  logic [BT_WIDTH-1:0]     BTIn,
    input  logic [NEURON_WIDTH-1:0] NIDIn,
    input  logic [BT_WIDTH-1:0]     Current_BT,
    input  logic                    DequeueIn,
    output logic [BT_WIDTH-1:0]     BTOut,
    output logic [NEURON_WIDTH-1:0] NIDOut,
    output logic                    Valid,
    output logic                    Empty,
    output logic                    Full,
`ifdef AUXQ_DROP_STATUS_EN
    output logic                    Overflow,
    output logic [15:0]             DropCount,
`endif
    output logic [DEPTH_LOG2:0]     Count
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = BT_WIDTH + NEURON_WIDTH;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);

    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [ENTRY_W-1:0]    head;
    logic                  empty, full, valid, deq_acc, enq_acc;

    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_CNT);
    assign head   = empty ? '0 : mem_q[rd_ptr_q];
    assign BTOut  = head[ENTRY_W-1:NEURON_WIDTH];
    assign NIDOut = head[NEURON_WIDTH-1:0];

    // Due test is purely combinational so a Current_BT step releases the head in the same cycle.
    assign valid   = !empty && (BTOut <= Current_BT);
    assign deq_acc = DequeueIn && valid;
    assign enq_acc = EnqueueIn && (!full || deq_acc);

    assign Valid = valid;
    assign Empty = empty;
    assign Full  = full;
    assign Count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (deq_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (enq_acc && !deq_acc)      count_d = count_q + CNT_ONE;
        else if (deq_acc && !enq_acc) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale contents are masked by Count.
    always_ff @(posedge Clock) begin
        if (enq_acc) mem_q[wr_ptr_q] <= {BTIn, NIDIn};
    end

`ifdef AUXQ_DROP_STATUS_EN
    logic        drop;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_count_q, drop_count_d;

    assign drop = EnqueueIn && full && !deq_acc;

    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign Overflow  = overflow_q;
    assign DropCount = drop_count_q;
`endif

endmodule

// File: tb/tb_aux_spike_queue.sv
// Self-checking bench for aux_spike_queue: vector table for the time gate, directed sequences for fill/drop,
// full bypass, pointer wrap and mid-operation reset.
`timescale 1ns/1ps
module tb_aux_spike_queue;
    localparam int BW = 36;
    localparam int NW = 11;
    localparam int DL = 4;

    logic          Clock = 1'b0;
    logic          Reset, EnqueueIn, DequeueIn;
    logic [BW-1:0] BTIn, Current_BT, BTOut;
    logic [NW-1:0] NIDIn, NIDOut;
    logic          Valid, Empty, Full;
    logic [DL:0]   Count;
`ifdef AUXQ_DROP_STATUS_EN
    logic          Overflow;
    logic [15:0]   DropCount;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clock = ~Clock;

    aux_spike_queue #(.BT_WIDTH(BW), .NEURON_WIDTH(NW), .DEPTH_LOG2(DL)) dut (
        .Clock(Clock), .Reset(Reset), .EnqueueIn(EnqueueIn), .BTIn(BTIn), .NIDIn(NIDIn),
        .Current_BT(Current_BT), .DequeueIn(DequeueIn), .BTOut(BTOut), .NIDOut(NIDOut),
        .Valid(Valid), .Empty(Empty), .Full(Full),
`ifdef AUXQ_DROP_STATUS_EN
        .Overflow(Overflow), .DropCount(DropCount),
`endif
        .Count(Count)
    );

    typedef struct {
        logic          enq;
        logic [BW-1:0] bt;
        logic [NW-1:0] nid;
        logic [BW-1:0] cur;
        logic          deq;
        logic          e_valid;
        logic          e_empty;
        logic          e_full;
        logic [DL:0]   e_count;
        logic [BW-1:0] e_bt;
        logic [NW-1:0] e_nid;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a falling edge; outputs are sampled 1 ns later, before the next rising edge.
    task automatic drive(input logic enq, input logic [BW-1:0] bt, input logic [NW-1:0] nid,
                         input logic [BW-1:0] cur, input logic deq);
        EnqueueIn  = enq;
        BTIn       = bt;
        NIDIn      = nid;
        Current_BT = cur;
        DequeueIn  = deq;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge Clock);
    endtask

    initial begin
        logic [NW-1:0] exp_nid[$];
        logic [BW-1:0] exp_bt[$];
        logic [BW-1:0] bt_max;
        bt_max = '1;

        // Time gate: BT 12 waits until Current_BT reaches 12; also enqueue into empty with dequeue held.
        // A BT with bit 35 set must not look due at small Current_BT.
        tv[0] = '{1'b0, 36'd0,           11'd0, 36'd0,           1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 36'd0,           11'd0};
        tv[1] = '{1'b1, 36'd12,          11'd5, 36'd10,          1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 36'd0,           11'd0};
        tv[2] = '{1'b0, 36'd0,           11'd0, 36'd10,          1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 36'd12,          11'd5};
        tv[3] = '{1'b0, 36'd0,           11'd0, 36'd11,          1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 36'd12,          11'd5};
        tv[4] = '{1'b0, 36'd0,           11'd0, 36'd12,          1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 36'd12,          11'd5};
        tv[5] = '{1'b0, 36'd0,           11'd0, 36'd12,          1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 36'd0,           11'd0};
        tv[6] = '{1'b1, 36'h800000000,   11'd7, 36'd12,          1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 36'd0,           11'd0};
        tv[7] = '{1'b0, 36'd0,           11'd0, 36'd12,          1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 36'h800000000,   11'd7};
        tv[8] = '{1'b0, 36'd0,           11'd0, 36'h800000000,   1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 36'h800000000,   11'd7};
        tv[9] = '{1'b0, 36'd0,           11'd0, 36'h800000000,   1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 36'd0,           11'd0};

        Reset = 1'b1;
        EnqueueIn = 1'b0; DequeueIn = 1'b0; BTIn = '0; NIDIn = '0; Current_BT = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("reset_empty", Empty, 1);
        chk("reset_full", Full, 0);
        chk("reset_valid", Valid, 0);
        chk("reset_count", Count, 0);
        chk("reset_bt", BTOut, 0);
        chk("reset_nid", NIDOut, 0);
`ifdef AUXQ_DROP_STATUS_EN
        chk("reset_overflow", Overflow, 0);
        chk("reset_dropcount", DropCount, 0);
`endif
        next_cycle();

        for (int i = 0; i < 10; i++) begin
            drive(tv[i].enq, tv[i].bt, tv[i].nid, tv[i].cur, tv[i].deq);
            $display("vec %0d: enq=%0d bt=%0h cur=%0h deq=%0d -> valid=%0d empty=%0d count=%0d head=%0h/%0d",
                     i, tv[i].enq, tv[i].bt, tv[i].cur, tv[i].deq, Valid, Empty, Count, BTOut, NIDOut);
            chk($sformatf("vec%0d_valid", i), Valid, tv[i].e_valid);
            chk($sformatf("vec%0d_empty", i), Empty, tv[i].e_empty);
            chk($sformatf("vec%0d_full", i), Full, tv[i].e_full);
            chk($sformatf("vec%0d_count", i), Count, tv[i].e_count);
            chk($sformatf("vec%0d_bt", i), BTOut, tv[i].e_bt);
            chk($sformatf("vec%0d_nid", i), NIDOut, tv[i].e_nid);
            next_cycle();
        end

        // Fill with BT 0..16 at Current_BT 0; the 17th is dropped.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, BW'(i), NW'(i), '0, 1'b0);
            if (i == 16) begin
                chk("fill_full_at17", Full, 1);
                chk("fill_count_at17", Count, 16);
            end
            next_cycle();
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        $display("fill: count=%0d full=%0d head_nid=%0d", Count, Full, NIDOut);
        chk("fill_count", Count, 16);
        chk("fill_full", Full, 1);
        chk("fill_head_nid", NIDOut, 0);
        chk("fill_valid", Valid, 1);
`ifdef AUXQ_DROP_STATUS_EN
        chk("fill_overflow", Overflow, 1);
        chk("fill_dropcount", DropCount, 1);
`endif
        next_cycle();

        // Full bypass: enqueue and dequeue together while full.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, BW'(20 + k), NW'(100 + k), 36'd100, 1'b1);
            $display("bypass %0d: pop nid=%0d count=%0d full=%0d", k, NIDOut, Count, Full);
            chk($sformatf("bypass%0d_nid", k), NIDOut, k);
            chk($sformatf("bypass%0d_count", k), Count, 16);
            chk($sformatf("bypass%0d_full", k), Full, 1);
            next_cycle();
        end
        drive(1'b0, '0, '0, 36'd100, 1'b0);
        chk("bypass_count_after", Count, 16);
        chk("bypass_full_after", Full, 1);
`ifdef AUXQ_DROP_STATUS_EN
        chk("bypass_no_drop", DropCount, 1);
`endif

        for (int j = 5; j < 16; j++) begin
            exp_nid.push_back(NW'(j));
            exp_bt.push_back(BW'(j));
        end
        for (int k = 0; k < 5; k++) begin
            exp_nid.push_back(NW'(100 + k));
            exp_bt.push_back(BW'(20 + k));
        end
        for (int j = 0; j < 16; j++) begin
            drive(1'b0, '0, '0, 36'd100, 1'b1);
            $display("drain %0d: bt=%0d nid=%0d", j, BTOut, NIDOut);
            chk($sformatf("drain%0d_nid", j), NIDOut, exp_nid[j]);
            chk($sformatf("drain%0d_bt", j), BTOut, exp_bt[j]);
            next_cycle();
        end
        drive(1'b0, '0, '0, 36'd100, 1'b0);
        chk("drain_empty", Empty, 1);

        // Wrap: 40 events streamed through at Current_BT = max.
        for (int c = 0; c <= 40; c++) begin
            drive(c < 40, BW'(c), NW'(c), bt_max, 1'b1);
            $display("wrap %0d: count=%0d valid=%0d nid=%0d", c, Count, Valid, NIDOut);
            chk($sformatf("wrap%0d_count", c), Count, (c == 0) ? 0 : 1);
            if (c > 0) chk($sformatf("wrap%0d_nid", c), NIDOut, c - 1);
            else       chk("wrap0_empty", Empty, 1);
            next_cycle();
        end
        drive(1'b0, '0, '0, bt_max, 1'b0);
        chk("wrap_empty_after", Empty, 1);

        // Mid-operation reset with 7 entries held and simultaneous enqueue/dequeue.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, BW'(i), NW'(50 + i), '0, 1'b0);
            next_cycle();
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        chk("midrst_count_before", Count, 7);
        Reset = 1'b1;
        drive(1'b1, '0, 11'd99, '0, 1'b1);
        next_cycle();
        Reset = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        $display("midreset: count=%0d empty=%0d valid=%0d", Count, Empty, Valid);
        chk("midrst_count", Count, 0);
        chk("midrst_empty", Empty, 1);
        chk("midrst_valid", Valid, 0);
        chk("midrst_nid", NIDOut, 0);
`ifdef AUXQ_DROP_STATUS_EN
        chk("midrst_overflow", Overflow, 0);
        chk("midrst_dropcount", DropCount, 0);
`endif
        drive(1'b1, 36'd3, 11'd77, '0, 1'b0);
        next_cycle();
        drive(1'b0, '0, '0, '0, 1'b0);
        chk("postrst_nid", NIDOut, 77);
        chk("postrst_bt", BTOut, 3);
        chk("postrst_count", Count, 1);
        chk("postrst_valid_early", Valid, 0);
        drive(1'b0, '0, '0, 36'd3, 1'b0);
        chk("postrst_valid_due", Valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aux_spike_queue.md
# aux_spike_queue

Time-gated FIFO that buffers spike events `{BT, NID}` emitted by the internal router and releases each one only once the network's current biological time reaches the event's scheduled time. It sits directly downstream of the router's auxiliary-queue outputs (`ToAuxEnqueueOut`, `ToAuxBTOut`, `ToAuxNIDOut`) and upstream of the synaptic/event processing stage, which drains it through a valid/dequeue handshake.

## Interface
- `BT_WIDTH`, 36: width of a biological-time stamp, unsigned.
- `NEURON_WIDTH`, 11: width of a neuron ID.
- `DEPTH_LOG2`, 4: log2 of the entry count; depth = 2**DEPTH_LOG2 = 16.

- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high; clock `Clock`.
- `EnqueueIn`  in  1  write request, from the router's aux-queue enqueue output.
- `BTIn`  in  BT_WIDTH  scheduled time of the incoming event.
- `NIDIn`  in  NEURON_WIDTH  global neuron ID of the incoming event.
- `Current_BT`  in  BT_WIDTH  network current time; the same value the router receives.
- `DequeueIn`  in  1  read request from the consumer.
- `BTOut`  out  BT_WIDTH  head entry's time stamp.
- `NIDOut`  out  NEURON_WIDTH  head entry's neuron ID.
- `Valid`  out  1  head exists and is due.
- `Empty`  out  1  count == 0.
- `Full`  out  1  count == 2**DEPTH_LOG2.
- `Count`  out  DEPTH_LOG2+1  number of stored entries.
- `Overflow`  out  1  sticky drop flag; present only with `AUXQ_DROP_STATUS_EN`.
- `DropCount`  out  16  number of dropped events; present only with `AUXQ_DROP_STATUS_EN`.

## Operation
- **Storage:** a 2**DEPTH_LOG2-entry array of `{BT, NID}`, plus registered `WrPtr` and `RdPtr` (DEPTH_LOG2 bits each, wrap modulo depth) and a registered `Count`.
- **Head presentation:** first-word-fall-through. `BTOut`/`NIDOut` = `array[RdPtr]` when not empty; both are forced to 0 when `Empty`.
- **Due test:** `Valid` = `!Empty && (BTOut <= Current_BT)`, an unsigned full-width compare. It is combinational from registered state and `Current_BT`.
- **Dequeue accept:** `DeqAcc` = `DequeueIn && Valid`.
  - On accept, `RdPtr` increments.
  - `DequeueIn` while `!Valid` is ignored, with no state change.
- **Enqueue accept:** `EnqAcc` = `EnqueueIn && (!Full || DeqAcc)`.
  - On accept, the entry is written at `WrPtr` and `WrPtr` increments.
- **Count update:** +1 on `EnqAcc` only; −1 on `DeqAcc` only; unchanged when both or neither occur.
- **Order:** strictly FIFO. There is no reordering by BT; the router produces BT values that are non-decreasing. An entry that is not yet due blocks all entries behind it.
- **Drop:** when `EnqueueIn && Full && !DeqAcc`, the event is discarded and the array and pointers are unchanged.
- **Reset:** pointers, `Count`, and all outputs go to 0; `Empty` = 1, `Full` = 0, `Valid` = 0. Array contents are don't-care. Reset asserted mid-operation discards all entries in the same edge and overrides any simultaneous enqueue or dequeue.

## Timing
- Enqueue into an empty queue at edge N: the entry is visible on `BTOut`/`NIDOut` and `Empty` falls after edge N. `Valid` can be high in cycle N+1 if the entry is due.
- Dequeue accepted at edge N: the next head appears after edge N. Sustained throughput is 1 dequeue per cycle.
- `Current_BT` increment makes `Valid` rise in the same cycle, with no register stage.
- **Full with simultaneous enqueue and accepted dequeue:** both take effect, `Count` stays at depth, and `Full` stays 1.
- **Empty with simultaneous enqueue and dequeue:** the dequeue is ignored and the enqueue is accepted.
- **Pointer wrap:** from 2**DEPTH_LOG2−1 to 0, with no bubble.

## Configuration
- `AUXQ_DROP_STATUS_EN` defined:
  - The `Overflow` and `DropCount` ports and registers exist.
  - `Overflow` sets on the first drop and clears only on `Reset`.
  - `DropCount` increments on each drop and saturates at 16'hFFFF.
  - Both reset to 0.
- Not defined: the ports and registers are absent and drops are silent. All other behaviour is identical.

## Test plan
- **Reset:** assert `Reset` for 2 cycles, then release → `Empty`=1, `Full`=0, `Valid`=0, `Count`=0, `BTOut`=0, `NIDOut`=0.
- **Time gate:** `Current_BT`=10, enqueue `{BT=12, NID=5}`; hold `DequeueIn`=1 → `Valid`=0 at BT 10 and 11; `Valid`=1 at BT 12, entry dequeued, `Empty`=1 next cycle.
- **Fill and drop:** enqueue 17 events with BT 0..16, `Current_BT`=0, no dequeue → `Count`=16, `Full`=1, 17th dropped. With the macro: `Overflow`=1, `DropCount`=1.
- **Full bypass:** queue full, `Current_BT`=100; assert `EnqueueIn` and `DequeueIn` for 5 cycles → 5 pops of NIDs in order, 5 new entries stored, `Count`=16 throughout, no drop.
- **Wrap:** with `Current_BT`=max, enqueue and dequeue 40 events at 1 per cycle → NIDs emerge 0..39 in order, `Count` never exceeds 2.
- **Mid-op reset:** with 7 entries held, assert `Reset` together with `EnqueueIn`/`DequeueIn` → `Count`=0, `Empty`=1 after the edge; next enqueue appears at the head.
